// File: rtl/obi_arb_pkg.sv
// Shared types and default widths for the OBI SRAM port arbiter.
// Master indices are sized for the largest supported master count (8).
package obi_arb_pkg;
  localparam int MAX_MASTERS     = 8;
  localparam int MST_IDX_W       = $clog2(MAX_MASTERS);
  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_OUTST   = 2;

  typedef logic [MST_IDX_W-1:0] mst_idx_t;
endpackage

// File: rtl/obi_arb_id_fifo.sv
// Outstanding-transaction FIFO holding the master index of each granted request.
// A push is accepted when full only if a pop happens in the same cycle.
module obi_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end
endmodule

// File: rtl/obi_sram_port_arbiter.sv
// N-to-1 OBI arbiter in front of one SRAM port; responses are routed back in order.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration, otherwise fixed priority.
module obi_sram_port_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_OUTST   = DEF_MAX_OUTST
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_req_i,
  output logic [NUM_MASTERS-1:0]          m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic                            s_req_o,
  input  logic                            s_gnt_i,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic                            s_we_o,
  output logic [DATA_W/8-1:0]             s_be_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  input  logic                            s_rvalid_i,
  input  logic [DATA_W-1:0]               s_rdata_i,
  output logic                            err_o
);
  localparam int BE_W = DATA_W/8;

  logic     fifo_full, fifo_empty;
  mst_idx_t fifo_head;
  mst_idx_t win_idx;
  logic     win_valid, can_issue, push, pop;
  logic     err_q, err_d;

  // A pop in the same cycle frees a slot, so a full FIFO may still accept a grant.
  assign pop       = s_rvalid_i && !fifo_empty;
  assign can_issue = !fifo_full || pop;

`ifdef OBI_ARB_ROUND_ROBIN_EN
  mst_idx_t rr_ptr_q, rr_ptr_d;

  function automatic mst_idx_t rr_idx(mst_idx_t base, int off);
    int c;
    c = (int'(base) + off) % NUM_MASTERS;
    return mst_idx_t'(c);
  endfunction

  // Search downwards so the candidate closest to rr_ptr_q is assigned last and wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (m_req_i[j] && (mst_idx_t'(j) == rr_idx(rr_ptr_q, k))) begin
          win_valid = 1'b1;
          win_idx   = mst_idx_t'(j);
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (win_idx == mst_idx_t'(NUM_MASTERS-1)) ? '0 : win_idx + mst_idx_t'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_MASTERS-1; i >= 0; i--) begin
      if (m_req_i[i]) begin
        win_valid = 1'b1;
        win_idx   = mst_idx_t'(i);
      end
    end
  end
`endif

  assign s_req_o   = win_valid && can_issue && !rst_i;
  assign push      = s_req_o && s_gnt_i;
  assign m_rdata_o = s_rdata_i;

  always_comb begin
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (s_req_o && (win_idx == mst_idx_t'(i))) begin
        s_addr_o   = m_addr_i[i*ADDR_W +: ADDR_W];
        s_we_o     = m_we_i[i];
        s_be_o     = m_be_i[i*BE_W +: BE_W];
        s_wdata_o  = m_wdata_i[i*DATA_W +: DATA_W];
        m_gnt_o[i] = s_gnt_i;
      end
      m_rvalid_o[i] = pop && !rst_i && (fifo_head == mst_idx_t'(i));
    end
  end

  // A response with nothing outstanding is dropped and latched as a protocol error.
  assign err_d = err_q || (s_rvalid_i && fifo_empty);
  assign err_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (MST_IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (win_idx),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );
endmodule

// File: tb/tb_obi_sram_port_arbiter.sv
// Directed bench for obi_sram_port_arbiter; expected grants and responses go into
// queues and a negedge monitor compares them whenever the DUT presents one.
module tb_obi_sram_port_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW/8;
  localparam int GW = N + AW + 1;
  localparam int RW = N + DW;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    m_req_i = '0;
  logic [N-1:0]    m_gnt_o;
  logic [N*AW-1:0] m_addr_i;
  logic [N-1:0]    m_we_i;
  logic [N*BW-1:0] m_be_i;
  logic [N*DW-1:0] m_wdata_i;
  logic [N-1:0]    m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            s_req_o;
  logic            s_gnt_i = 1'b0;
  logic [AW-1:0]   s_addr_o;
  logic            s_we_o;
  logic [BW-1:0]   s_be_o;
  logic [DW-1:0]   s_wdata_o;
  logic            s_rvalid_i = 1'b0;
  logic [DW-1:0]   s_rdata_i = '0;
  logic            err_o;

  int checks = 0;
  int errors = 0;
  logic [GW-1:0] gnt_q[$];
  logic [RW-1:0] rsp_q[$];
  logic [N-1:0]  g, prev;
  logic [N-1:0]  gnt_rr_tbl [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  obi_sram_port_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_OUTST   (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .m_req_i    (m_req_i),
    .m_gnt_o    (m_gnt_o),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_req_o    (s_req_o),
    .s_gnt_i    (s_gnt_i),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .err_o      (err_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // M0 writes to 0x10, M1 reads from 0x100
  initial begin
    m_addr_i  = {32'h0000_0100, 32'h0000_0010};
    m_we_i    = 2'b01;
    m_be_i    = {4'h0, 4'hF};
    m_wdata_i = {32'h0, 32'h1234_5678};
  end

  function automatic logic [AW-1:0] addr_of(logic [N-1:0] gv);
    return gv[0] ? 32'h0000_0010 : 32'h0000_0100;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    repeat (2) cyc();
    rst_i = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [GW-1:0] eg;
    logic [RW-1:0] er;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (m_gnt_o != '0) begin
          if (gnt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_gnt: got %b expected none", m_gnt_o);
          end else begin
            eg = gnt_q.pop_front();
            check("gnt", 64'({m_gnt_o, s_addr_o, s_we_o}), 64'(eg));
          end
        end
        if (m_rvalid_o != '0) begin
          if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got %b expected none", m_rvalid_o);
          end else begin
            er = rsp_q.pop_front();
            check("rsp", 64'({m_rvalid_o, m_rdata_o}), 64'(er));
          end
        end
      end
    end
  end

  // Driver
  initial begin
    // Outputs held low while in reset even with active inputs
    m_req_i = 2'b11; s_gnt_i = 1'b1; s_rvalid_i = 1'b1;
    #2;
    check("rst_s_req", 64'(s_req_o), 64'd0);
    check("rst_m_gnt", 64'(m_gnt_o), 64'd0);
    check("rst_m_rvalid", 64'(m_rvalid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_s_addr", 64'(s_addr_o), 64'd0);

    // Both masters request back-to-back with s_gnt_i=1
    do_reset();
    m_req_i = 2'b11;
    s_gnt_i = 1'b1;
    prev    = '0;
    for (int k = 0; k < 4; k++) begin
      s_rvalid_i = (k > 0);
      s_rdata_i  = 32'hA000_0000 + k;
`ifdef OBI_ARB_ROUND_ROBIN_EN
      g = gnt_rr_tbl[k];
`else
      g = 2'b01;
`endif
      gnt_q.push_back({g, addr_of(g), g[0]});
      if (k > 0) rsp_q.push_back({prev, s_rdata_i});
      prev = g;
      cyc();
    end
    m_req_i    = '0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hA000_0004;
    rsp_q.push_back({prev, s_rdata_i});
    cyc();
    s_rvalid_i = 1'b0;

    // M1 read of 0x100 returning 0xDEADBEEF one cycle later
    do_reset();
    m_req_i = 2'b10;
    s_gnt_i = 1'b1;
    gnt_q.push_back({2'b10, 32'h0000_0100, 1'b0});
    cyc();
    m_req_i    = '0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEAD_BEEF;
    rsp_q.push_back({2'b10, 32'hDEAD_BEEF});
    cyc();
    s_rvalid_i = 1'b0;

    // Gnt stall, then FIFO fill to MAX_OUTST, then full-with-pop
    do_reset();
    m_req_i = 2'b01;
    s_gnt_i = 1'b0;
    #1;
    check("stall_s_req", 64'(s_req_o), 64'd1);
    check("stall_m_gnt", 64'(m_gnt_o), 64'd0);
    cyc();
    s_gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      gnt_q.push_back({2'b01, 32'h0000_0010, 1'b1});
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      check("full_s_req", 64'(s_req_o), 64'd0);
      cyc();
    end
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hC000_0000;
    gnt_q.push_back({2'b01, 32'h0000_0010, 1'b1});
    rsp_q.push_back({2'b01, 32'hC000_0000});
    cyc();
    m_req_i = '0;
    for (int k = 1; k < 3; k++) begin
      s_rdata_i = 32'hC000_0000 + k;
      rsp_q.push_back({2'b01, s_rdata_i});
      cyc();
    end
    s_rvalid_i = 1'b0;
    check("drain_err", 64'(err_o), 64'd0);

    // Stray response with nothing outstanding
    do_reset();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h5555_AAAA;
    #1;
    check("stray_rvalid", 64'(m_rvalid_o), 64'd0);
    cyc();
    s_rvalid_i = 1'b0;
    check("stray_err_set", 64'(err_o), 64'd1);
    repeat (3) cyc();
    check("stray_err_sticky", 64'(err_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check("stray_err_clear", 64'(err_o), 64'd0);

    // Reset with two transactions outstanding
    do_reset();
    m_req_i = 2'b01;
    s_gnt_i = 1'b1;
    gnt_q.push_back({2'b01, 32'h0000_0010, 1'b1});
    cyc();
    m_req_i = 2'b10;
    gnt_q.push_back({2'b10, 32'h0000_0100, 1'b0});
    cyc();
    m_req_i    = 2'b11;
    s_rvalid_i = 1'b1;
    rst_i      = 1'b1;
    #1;
    check("midrst_s_req", 64'(s_req_o), 64'd0);
    check("midrst_m_gnt", 64'(m_gnt_o), 64'd0);
    check("midrst_m_rvalid", 64'(m_rvalid_o), 64'd0);
    cyc();
    rst_i   = 1'b0;
    m_req_i = '0;
    #1;
    check("postrst_rvalid", 64'(m_rvalid_o), 64'd0);
    cyc();
    s_rvalid_i = 1'b0;
    check("postrst_err", 64'(err_o), 64'd1);

    repeat (2) cyc();
    check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/obi_sram_port_arbiter.md
OBI_SRAM_PORT_ARBITER -- requirements
Module: obi_sram_port_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_MASTERS, default 2, number of upstream OBI masters (2..8).
REQ-002 Parameters SHALL include: ADDR_W, default 32, address width.
REQ-003 Parameters SHALL include: DATA_W, default 32, data width; BE width = DATA_W/8.
REQ-004 Parameters SHALL include: MAX_OUTST, default 2, outstanding-transaction FIFO depth (power of 2, ≥2).
REQ-005 Ports SHALL be: clk_i  in  1  single clock, all logic on rising edge.
REQ-006 Ports SHALL include: rst_i  in  1  asynchronous, active-high reset.
REQ-007 Ports SHALL include: m_req_i  in  NUM_MASTERS  per-master OBI request.
REQ-008 Ports SHALL include: m_gnt_o  out  NUM_MASTERS  per-master grant.
REQ-009 Ports SHALL include: m_addr_i  in  NUM_MASTERS×ADDR_W, m_we_i  in  NUM_MASTERS, m_be_i  in  NUM_MASTERS×DATA_W/8, m_wdata_i  in  NUM_MASTERS×DATA_W.
REQ-010 Ports SHALL include: m_rvalid_o  out  NUM_MASTERS, m_rdata_o  out  DATA_W (shared, qualified by m_rvalid_o).
REQ-011 Ports SHALL include: s_req_o  out  1, s_gnt_i  in  1, s_addr_o  out  ADDR_W, s_we_o  out  1, s_be_o  out  DATA_W/8, s_wdata_o  out  DATA_W: request to one port of the double-port SRAM.
REQ-012 Ports SHALL include: s_rvalid_i  in  1, s_rdata_i  in  DATA_W: SRAM port response.
REQ-013 Ports SHALL include: err_o  out  1  sticky protocol-error flag.

Function
REQ-014 Arbitration SHALL be combinational: winner chosen among asserted m_req_i when outstanding FIFO is not full; s_req_o = winner valid.
REQ-015 s_addr_o/s_we_o/s_be_o/s_wdata_o SHALL be muxed from the winner in the same cycle; zero when no winner.
REQ-016 m_gnt_o[w] SHALL equal s_gnt_i AND s_req_o for the winner w only; all others 0.
REQ-017 On handshake (s_req_o && s_gnt_i) winner index SHALL be pushed into outstanding FIFO.
REQ-018 On s_rvalid_i, FIFO head SHALL be popped; m_rvalid_o[head] = 1 same cycle; m_rdata_o = s_rdata_i (combinational pass-through).
REQ-019 Simultaneous push and pop SHALL both occur; occupancy unchanged.
REQ-020 FIFO full (MAX_OUTST entries) SHALL force s_req_o = 0 and all m_gnt_o = 0, unless a pop occurs that cycle (full-with-pop permits grant).
REQ-021 s_rvalid_i with empty FIFO SHALL be dropped (no m_rvalid_o) and set err_o until reset.
REQ-022 Latency: request to SRAM 0 cycles added; response to master 0 cycles added.
REQ-023 Round-robin pointer (when enabled) SHALL advance to winner+1 mod NUM_MASTERS only on handshake; unchanged on gnt-stall.

Reset
REQ-024 While rst_i high: FIFO empty, RR pointer 0, err_o 0, m_gnt_o 0, m_rvalid_o 0, s_req_o 0.
REQ-025 Reset mid-operation SHALL discard in-flight entries; responses arriving after release with empty FIFO follow REQ-021.

Configuration
REQ-026 Macro OBI_ARB_ROUND_ROBIN_EN defined: round-robin starting search at RR pointer.
REQ-027 Macro undefined: fixed priority, lowest index wins; RR pointer register not instantiated.

Structure
REQ-028 Package obi_arb_pkg SHALL hold master-index typedef (clog2 NUM_MASTERS) and default width constants.
REQ-029 Outstanding FIFO SHALL be sub-module obi_arb_id_fifo (parameters depth, width; push/pop/full/empty/head).

Verification
REQ-030 Two masters request together, RR enabled, s_gnt_i=1 -> grants M0, M1, M0, M1 on consecutive cycles.
REQ-031 Same stimulus, macro undefined -> M0 granted every cycle, M1 never.
REQ-032 M1 reads 0x100, SRAM returns 0xDEADBEEF next cycle -> m_rvalid_o=2'b10, m_rdata_o=0xDEADBEEF.
REQ-033 s_rvalid_i held 0, M0 requests continuously -> exactly MAX_OUTST=2 grants, then gnt low until rvalid.
REQ-034 s_rvalid_i pulse after reset with no request -> no m_rvalid_o, err_o=1 until rst_i.
REQ-035 rst_i asserted with 2 outstanding -> all outputs 0 immediately, FIFO empty after release.
